// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one pipelined signed 16x16 multiplier among
// NREQ requesters. Grants are issued combinationally and launched into the
// multiplier from a register stage. A tag pipeline follows each launched
// operation so that every product comes back labelled with its requester ID.
// Any disagreement between the multiplier's enable_out and the tag pipeline
// sets a sticky error flag.
module mult_share_sched #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MULT_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 clear,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mult_x,
  output logic [15:0]          mult_y,
  output logic                 mult_en,
  input  logic [30:0]          mult_product,
  input  logic                 mult_en_out,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [30:0]          res_product,
  output logic [31:0]          ops_count,
  output logic                 tag_err
);

  localparam int LAST = MULT_LAT;

  logic [IDW-1:0] ptr;
  logic           gnt_hit;
  logic [IDW-1:0] gnt_id;
  logic [15:0]    gnt_x;
  logic [15:0]    gnt_y;
  logic [IDW-1:0] ptr_next;

  // Tag pipeline: stage 0 lines up with mult_en, stage LAST with mult_en_out.
  logic [LAST:0]  tag_valid;
  logic [LAST:0]  tag_drop;
  logic [IDW-1:0] tag_id [0:LAST];

  // Round-robin search starting at ptr; grants are blocked during reset,
  // while run is low, and in a clear cycle.
  always_comb begin
    int idx;
    gnt_hit = 1'b0;
    gnt_id  = '0;
    gnt_x   = '0;
    gnt_y   = '0;
    idx     = 0;
    if (reset_n && run && !clear) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!gnt_hit && req_valid[idx]) begin
          gnt_hit = 1'b1;
          gnt_id  = idx[IDW-1:0];
          gnt_x   = req_x[16*idx +: 16];
          gnt_y   = req_y[16*idx +: 16];
        end
      end
    end
  end

  // One-hot grant and the pointer value that follows a transfer.
  always_comb begin
    int nxt;
    req_ready = '0;
    nxt       = (int'(gnt_id) + 1) % NREQ;
    ptr_next  = nxt[IDW-1:0];
    if (gnt_hit) req_ready[gnt_id] = 1'b1;
  end

  // Pointer, issue register and accepted-op counter; clear takes priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      mult_x    <= '0;
      mult_y    <= '0;
      mult_en   <= 1'b0;
      ops_count <= '0;
    end else if (clear) begin
      ptr       <= '0;
      mult_x    <= '0;
      mult_y    <= '0;
      mult_en   <= 1'b0;
      ops_count <= '0;
    end else begin
      mult_x  <= gnt_hit ? gnt_x : 16'd0;
      mult_y  <= gnt_hit ? gnt_y : 16'd0;
      mult_en <= gnt_hit;
      if (gnt_hit) begin
        ptr       <= ptr_next;
        ops_count <= ops_count + 32'd1;
      end
    end
  end

  // Shift tags along with the multiplier; clear marks everything in flight
  // as dropped so it still checks alignment but never reports a result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_drop  <= '0;
      for (int k = 0; k <= LAST; k++) tag_id[k] <= '0;
    end else begin
      tag_valid[0] <= gnt_hit;
      tag_drop[0]  <= 1'b0;
      tag_id[0]    <= gnt_id;
      for (int k = 1; k <= LAST; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_drop[k]  <= tag_drop[k-1] | (clear & tag_valid[k-1]);
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  // Sticky misalignment flag between enable_out and the last tag stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_err <= 1'b0;
    end else if (clear) begin
      tag_err <= 1'b0;
    end else if (mult_en_out != tag_valid[LAST]) begin
      tag_err <= 1'b1;
    end
  end

  // A result leaving in a clear cycle is suppressed along with the flush.
  always_comb begin
    res_valid   = mult_en_out & tag_valid[LAST] & ~tag_drop[LAST] & ~clear;
    res_id      = res_valid ? tag_id[LAST] : '0;
    res_product = mult_product;
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched with a behavioural one-cycle multiplier.
module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock;
  logic              reset_n;
  logic              run;
  logic              clear;
  logic [NREQ-1:0]   req_valid;
  logic [16*NREQ-1:0] req_x;
  logic [16*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic [15:0]       mult_x;
  logic [15:0]       mult_y;
  logic              mult_en;
  logic [30:0]       mult_product;
  logic              mult_en_out;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [30:0]       res_product;
  logic [31:0]       ops_count;
  logic              tag_err;

  logic              m_en_q;
  logic [30:0]       m_prod_q;
  logic              inject;
  logic signed [31:0] prod_full;

  int n_tests;
  int n_fail;

  mult_share_sched #(.NREQ(NREQ), .IDW(IDW), .MULT_LAT(1)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .clear(clear),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .mult_x(mult_x), .mult_y(mult_y), .mult_en(mult_en),
    .mult_product(mult_product), .mult_en_out(mult_en_out),
    .res_valid(res_valid), .res_id(res_id), .res_product(res_product),
    .ops_count(ops_count), .tag_err(tag_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural multiplier: one-cycle latency, outputs 0 when not enabled.
  assign prod_full = $signed(mult_x) * $signed(mult_y);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_en_q   <= 1'b0;
      m_prod_q <= '0;
    end else begin
      m_en_q   <= mult_en;
      m_prod_q <= mult_en ? prod_full[30:0] : 31'd0;
    end
  end
  assign mult_en_out  = m_en_q | inject;
  assign mult_product = m_prod_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[16*i +: 16] = x;
    req_y[16*i +: 16] = y;
  endtask

  function automatic logic [31:0] p31(input int v);
    logic [31:0] t;
    t = v;
    return {1'b0, t[30:0]};
  endfunction

  int exp_ids3 [4] = '{1, 3, 1, 3};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    run = 1'b1;
    clear = 1'b0;
    inject = 1'b0;
    req_valid = 4'hF;
    req_x = '0;
    req_y = '0;
    #1;
    // reset state
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_en", 32'(mult_en), 32'h0);
    chk("rst_ops", ops_count, 32'h0);
    chk("rst_err", 32'(tag_err), 32'h0);
    req_valid = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();

    // single request: 3 * -5 from requester 0
    set_op(0, 16'd3, -16'sd5);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_en", 32'(mult_en), 32'h1);
    chk("t1_x", 32'(mult_x), 32'h0003);
    tick();
    chk("t1_rv", 32'(res_valid), 32'h1);
    chk("t1_id", 32'(res_id), 32'h0);
    chk("t1_prod", {1'b0, res_product}, p31(-15));
    chk("t1_ops", ops_count, 32'd1);
    tick();
    chk("t1_rv_off", 32'(res_valid), 32'h0);

    // clear to return the pointer to 0, then all four request continuously
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i + 1), 16'd2);
    for (int k = 0; k < 10; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("t2_rv", 32'(res_valid), 32'h1);
        chk("t2_id", 32'(res_id), 32'((k - 2) % 4));
        chk("t2_prod", {1'b0, res_product}, p31((((k - 2) % 4) + 1) * 2));
      end
      tick();
    end
    chk("t2_ops", ops_count, 32'd8);

    // requesters 1 and 3 only, starting from ptr=2 after one grant to 1
    set_op(1, 16'h8000, 16'h8000);
    set_op(3, 16'h8000, 16'h8000);
    req_valid = 4'b0010;
    #1;
    chk("t3_pre", 32'(req_ready), 32'h2);
    tick();
    for (int j = 0; j < 5; j++) begin
      req_valid = (j < 3) ? 4'b1010 : 4'b0000;
      #1;
      if (j < 3) chk("t3_ready", 32'(req_ready), (j == 1) ? 32'h2 : 32'h8);
      if (j >= 1) begin
        chk("t3_rv", 32'(res_valid), 32'h1);
        chk("t3_id", 32'(res_id), 32'(exp_ids3[j-1]));
        chk("t3_prod", {1'b0, res_product}, 32'd1073741824);
      end
      tick();
    end
    chk("t3_ops", ops_count, 32'd12);

    // clear one cycle after two back-to-back accepts
    set_op(0, 16'd7, 16'd7);
    set_op(1, 16'd5, 16'd5);
    req_valid = 4'b0001;
    #1;
    chk("t4_a0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("t4_a1", 32'(req_ready), 32'h2);
    tick();
    clear = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("t4_clr_ready", 32'(req_ready), 32'h0);
    chk("t4_clr_rv", 32'(res_valid), 32'h0);
    tick();
    clear = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("t4_drop_en", 32'(mult_en_out), 32'h1);
    chk("t4_drop_rv", 32'(res_valid), 32'h0);
    chk("t4_ops", ops_count, 32'd0);
    chk("t4_err", 32'(tag_err), 32'h0);
    tick();
    req_valid = 4'hF;
    #1;
    chk("t4_ptr0", 32'(req_ready), 32'h1);
    chk("t4_err2", 32'(tag_err), 32'h0);
    req_valid = 4'h0;
    tick();

    // spurious enable_out with nothing in flight
    inject = 1'b1;
    #1;
    chk("t5_inj_rv", 32'(res_valid), 32'h0);
    tick();
    inject = 1'b0;
    #1;
    chk("t5_err", 32'(tag_err), 32'h1);
    tick();
    chk("t5_err_hold", 32'(tag_err), 32'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("t5_err_clr", 32'(tag_err), 32'h0);

    // run falls right after an accept
    req_valid = 4'hF;
    #1;
    chk("t6_acc", 32'(req_ready), 32'h1);
    tick();
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_ready", 32'(req_ready), 32'h0);
      if (k == 1) begin
        chk("t6_rv", 32'(res_valid), 32'h1);
        chk("t6_prod", {1'b0, res_product}, p31(49));
      end
      tick();
    end
    chk("t6_ops", ops_count, 32'd1);
    run = 1'b1;

    // reset asserted mid-operation
    #1;
    chk("t7_acc", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'h0;
    chk("t7_en", 32'(mult_en), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("t7_en_rst", 32'(mult_en), 32'h0);
    chk("t7_ops_rst", ops_count, 32'h0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t7_rv", 32'(res_valid), 32'h0);
      tick();
    end
    chk("t7_err", 32'(tag_err), 32'h0);
    req_valid = 4'hF;
    #1;
    chk("t7_ptr0", 32'(req_ready), 32'h1);
    req_valid = 4'h0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
